// File: rtl/alu_iter_if.sv
// alu_iter_if: operation/result handshake bundle for alu_iter.
//   in_valid/in_ready   : operation handshake (ALUctl, MDUctl, A, B)
//   out_valid/out_ready : result handshake (ALUOut)
//   master modport = producer/consumer side, slave modport = alu_iter side.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       ALUctl;
  logic [7:0]       MDUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUOut;

  modport master (
    output in_valid, ALUctl, MDUctl, A, B, out_ready,
    input  in_ready, out_valid, ALUOut
  );

  modport slave (
    input  in_valid, ALUctl, MDUctl, A, B, out_ready,
    output in_ready, out_valid, ALUOut
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: RV32I-style ALU with optional iterative M-extension unit.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_iter_if.slave (operation in, registered result out)
// Base ops complete in one cycle. With macro ALU_ITER_MULDIV_EN defined,
// MUL-class ops use a radix-2 shift-add multiplier and DIV-class ops a
// restoring divider, each taking WIDTH iterations; divide-by-zero and
// signed overflow take the one-cycle path. Without the macro, MDUctl is
// ignored and every op takes the one-cycle path.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_iter_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_ITER_MULDIV_EN
    ITER = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             accept_c;
  logic [WIDTH-1:0] base_res_c;
  logic [SHW-1:0]   shamt_c;
  logic             lt_s_c, lt_u_c;

  assign accept_c      = bus.in_valid & in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUOut    = aluout_q;

  // Single-cycle base ALU; lowest set ALUctl bit wins if several are set
  always_comb begin
    shamt_c    = bus.B[SHW-1:0];
    lt_s_c     = $signed(bus.A) < $signed(bus.B);
    lt_u_c     = bus.A < bus.B;
    base_res_c = '0;
    if      (bus.ALUctl[0]) base_res_c = {{(WIDTH-1){1'b0}}, lt_u_c};
    else if (bus.ALUctl[1]) base_res_c = {{(WIDTH-1){1'b0}}, lt_s_c};
    else if (bus.ALUctl[2]) base_res_c = bus.A + bus.B;
    else if (bus.ALUctl[3]) base_res_c = bus.A - bus.B;
    else if (bus.ALUctl[4]) base_res_c = bus.A ^ bus.B;
    else if (bus.ALUctl[5]) base_res_c = bus.A | bus.B;
    else if (bus.ALUctl[6]) base_res_c = bus.A & bus.B;
    else if (bus.ALUctl[7]) base_res_c = bus.A << shamt_c;
    else if (bus.ALUctl[8]) base_res_c = bus.A >> shamt_c;
    else if (bus.ALUctl[9]) base_res_c = $unsigned($signed(bus.A) >>> shamt_c);
  end

`ifdef ALU_ITER_MULDIV_EN
  localparam int unsigned      W2      = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Shared iteration datapath: hi = partial product / remainder,
  // lo = multiplier / dividend-quotient, mcand = multiplicand / divisor
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             want_hi_q, want_hi_d;
  logic             neg_q, neg_d;

  logic             a_neg_c, b_neg_c, b_zero_c, ovf_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic             mdu_iter_c, ld_div_c, ld_hi_c, ld_neg_c;
  logic [WIDTH-1:0] ld_lo_c, ld_mcand_c, fast_res_c;

  // Accept-time decode: operand magnitudes, result sign, fast-path results
  always_comb begin
    a_neg_c    = bus.A[WIDTH-1];
    b_neg_c    = bus.B[WIDTH-1];
    abs_a_c    = a_neg_c ? (~bus.A + WIDTH'(1)) : bus.A;
    abs_b_c    = b_neg_c ? (~bus.B + WIDTH'(1)) : bus.B;
    b_zero_c   = (bus.B == '0);
    ovf_c      = (bus.A == MIN_NEG) && (bus.B == ONES);
    mdu_iter_c = 1'b0;
    ld_div_c   = 1'b0;
    ld_hi_c    = 1'b0;
    ld_neg_c   = 1'b0;
    ld_lo_c    = bus.B;
    ld_mcand_c = bus.A;
    fast_res_c = base_res_c;
    if (bus.MDUctl[0]) begin
      mdu_iter_c = 1'b1;
    end else if (bus.MDUctl[1]) begin
      mdu_iter_c = 1'b1;
      ld_hi_c    = 1'b1;
      ld_lo_c    = abs_b_c;
      ld_mcand_c = abs_a_c;
      ld_neg_c   = a_neg_c ^ b_neg_c;
    end else if (bus.MDUctl[2]) begin
      mdu_iter_c = 1'b1;
      ld_hi_c    = 1'b1;
      ld_mcand_c = abs_a_c;
      ld_neg_c   = a_neg_c;
    end else if (bus.MDUctl[3]) begin
      mdu_iter_c = 1'b1;
      ld_hi_c    = 1'b1;
    end else if (bus.MDUctl[4]) begin
      if (b_zero_c)   fast_res_c = ONES;
      else if (ovf_c) fast_res_c = bus.A;
      else begin
        mdu_iter_c = 1'b1;
        ld_div_c   = 1'b1;
        ld_lo_c    = abs_a_c;
        ld_mcand_c = abs_b_c;
        ld_neg_c   = a_neg_c ^ b_neg_c;
      end
    end else if (bus.MDUctl[5]) begin
      if (b_zero_c) fast_res_c = ONES;
      else begin
        mdu_iter_c = 1'b1;
        ld_div_c   = 1'b1;
        ld_lo_c    = bus.A;
        ld_mcand_c = bus.B;
      end
    end else if (bus.MDUctl[6]) begin
      if (b_zero_c)   fast_res_c = bus.A;
      else if (ovf_c) fast_res_c = '0;
      else begin
        mdu_iter_c = 1'b1;
        ld_div_c   = 1'b1;
        ld_hi_c    = 1'b1;
        ld_lo_c    = abs_a_c;
        ld_mcand_c = abs_b_c;
        ld_neg_c   = a_neg_c;
      end
    end else if (bus.MDUctl[7]) begin
      if (b_zero_c) fast_res_c = bus.A;
      else begin
        mdu_iter_c = 1'b1;
        ld_div_c   = 1'b1;
        ld_hi_c    = 1'b1;
        ld_lo_c    = bus.A;
        ld_mcand_c = bus.B;
      end
    end
  end

  logic [WIDTH:0]   sum_c, sh_c, diff_c;
  logic [WIDTH-1:0] hi_n_c, lo_n_c, qr_c, fin_res_c;
  logic [W2-1:0]    prod_c;

  // One iteration step plus the sign fix used on the final step
  always_comb begin
    sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    sh_c   = {hi_q, lo_q[WIDTH-1]};
    diff_c = sh_c - {1'b0, mcand_q};
    if (is_div_q) begin
      // restoring step: keep the difference only when it did not borrow
      if (!diff_c[WIDTH]) begin
        hi_n_c = diff_c[WIDTH-1:0];
        lo_n_c = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n_c = sh_c[WIDTH-1:0];
        lo_n_c = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n_c = sum_c[WIDTH:1];
      lo_n_c = {sum_c[0], lo_q[WIDTH-1:1]};
    end
    prod_c = {hi_n_c, lo_n_c};
    if (neg_q) prod_c = ~prod_c + W2'(1);
    qr_c = want_hi_q ? hi_n_c : lo_n_c;
    if (neg_q) qr_c = ~qr_c + WIDTH'(1);
    if (is_div_q)       fin_res_c = qr_c;
    else if (want_hi_q) fin_res_c = prod_c[W2-1:WIDTH];
    else                fin_res_c = prod_c[WIDTH-1:0];
  end
`else
  logic unused_mdu;
  assign unused_mdu = ^bus.MDUctl;
`endif

  // Next-state and datapath load
  always_comb begin
    state_d  = state_q;
    aluout_d = aluout_q;
`ifdef ALU_ITER_MULDIV_EN
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    want_hi_d = want_hi_q;
    neg_d     = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
`ifdef ALU_ITER_MULDIV_EN
          if (mdu_iter_c) begin
            state_d   = ITER;
            cnt_d     = '0;
            hi_d      = '0;
            lo_d      = ld_lo_c;
            mcand_d   = ld_mcand_c;
            is_div_d  = ld_div_c;
            want_hi_d = ld_hi_c;
            neg_d     = ld_neg_c;
          end else begin
            state_d  = DONE;
            aluout_d = fast_res_c;
          end
`else
          state_d  = DONE;
          aluout_d = base_res_c;
`endif
        end
      end
`ifdef ALU_ITER_MULDIV_EN
      ITER: begin
        hi_d  = hi_n_c;
        lo_d  = lo_n_c;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = DONE;
          aluout_d = fin_res_c;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aluout_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_ITER_MULDIV_EN
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      want_hi_q <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      aluout_q    <= aluout_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
`ifdef ALU_ITER_MULDIV_EN
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      want_hi_q <= want_hi_d;
      neg_q     <= neg_d;
`endif
    end
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation presented on ALUctl/MDUctl/A/B.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 ALUctl  input  10  one-hot base op: [0] SLTU, [1] SLT, [2] ADD, [3] SUB, [4] XOR, [5] OR, [6] AND, [7] SLL, [8] SRL, [9] SRA.
REQ-007 MDUctl  input  8  one-hot M op: [0] MUL, [1] MULH, [2] MULHSU, [3] MULHU, [4] DIV, [5] DIVU, [6] REM, [7] REMU.
REQ-008 A, B  input  WIDTH  operands; A is dividend/rs1, B is divisor/rs2.
REQ-009 out_valid  output  1  ALUOut holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALUOut  output  WIDTH  registered result.

Function
REQ-012 FSM states SHALL be IDLE, ITER, DONE; in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-013 Base op accepted in cycle N: IDLE->DONE, out_valid=1 in cycle N+1, ALUOut = RV32I semantics widened to WIDTH; shift amount = B[log2(WIDTH)-1:0]; SLT/SLTU yield 0 or 1 zero-extended.
REQ-014 MUL-class op accepted in cycle N: IDLE->ITER, radix-2 shift-add over WIDTH iterations, out_valid=1 in cycle N+WIDTH+1; MUL returns low WIDTH bits, MULH/MULHSU/MULHU the high WIDTH bits of the 2*WIDTH signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-015 DIV-class op accepted in cycle N: restoring division over WIDTH iterations on magnitudes, sign fix applied on ITER->DONE, out_valid=1 in cycle N+WIDTH+1; quotient truncates toward zero, remainder takes dividend sign.
REQ-016 Divide by zero SHALL take the 1-cycle path: DIV/DIVU -> all ones, REM/REMU -> A.
REQ-017 Signed overflow (A = most-negative, B = -1) SHALL take the 1-cycle path: DIV -> A, REM -> 0.
REQ-018 In DONE, ALUOut and out_valid SHALL hold stable until out_ready=1; DONE->IDLE on that cycle; out_valid falls the following cycle.
REQ-019 Nonzero MDUctl SHALL take priority over ALUctl; both zero -> ALUOut=0 via 1-cycle path.
REQ-020 Inputs are sampled only at accept; changes on A/B/ctl during ITER or DONE SHALL not affect the result.
REQ-021 ALUOut SHALL keep its last value outside DONE; no X on any output after reset.

Reset
REQ-022 rst=1 SHALL force state IDLE, out_valid=0, ALUOut=0, iteration counter=0 at the next edge, regardless of state.
REQ-023 rst asserted during ITER or DONE SHALL abort the operation; no out_valid for it is ever produced.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro ALU_ITER_MULDIV_EN: defined -> REQ-014..017 implemented as specified.
REQ-026 Without ALU_ITER_MULDIV_EN: no ITER state, multiplier, or divider logic; MDUctl port retained but ignored; every accepted op takes the 1-cycle path with ALUctl decoding (MDUctl-only op -> ALUOut=0).

Verification (WIDTH=32, macro defined unless stated)
REQ-027 ADD A=5 B=7 accepted cycle N -> out_valid cycle N+1, ALUOut=0x0000000C; SRA A=0x80000000 B=4 -> 0xF8000000.
REQ-028 MUL A=0xFFFFFFFF B=3 accepted cycle N -> out_valid exactly cycle N+33, ALUOut=0xFFFFFFFD; MULHU same operands -> 0x00000002; MULH -> 0xFFFFFFFF.
REQ-029 DIV A=0xFFFFFFF9 (-7) B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0x1234/0 -> 0xFFFFFFFF at N+1; REM 0x80000000/0xFFFFFFFF -> 0x00000000 at N+1.
REQ-030 Backpressure: out_ready=0 for 3 cycles after out_valid -> ALUOut stable, in_ready=0; in_valid held with new op accepted one cycle after out_ready=1.
REQ-031 rst pulsed at cycle N+10 of a DIVU -> out_valid never asserts for it, ALUOut=0, in_ready=1 the cycle after rst falls.
REQ-032 Macro undefined: MDUctl=MUL, ALUctl=0, A=3 B=4 -> out_valid at N+1, ALUOut=0.
